// File: rtl/decode_unit.sv
// RV32I instruction decoder: splits the word into fields, classifies the format and
// builds the sign-extended immediate. Every output is registered, so latency is one cycle.
module decode_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    input  logic [31:0] inst,
    output logic        dec_valid,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  funct7,
    output logic [31:0] imm,
    output logic [2:0]  fmt,
    output logic        rd_we,
    output logic        rs1_used,
    output logic        rs2_used,
    output logic        illegal
);

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    fmt_e        fmt_d;
    logic [31:0] imm_d;
    logic        rd_we_d;
    logic        rs1_used_d;
    logic        rs2_used_d;
    logic        sgn;

    assign sgn = inst[31];

    always_comb begin
        fmt_d = FMT_ILL;
        case (inst[6:0])
            7'b0110011:                                     fmt_d = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111,
            7'b1110011, 7'b0001111:                         fmt_d = FMT_I;
            7'b0100011:                                     fmt_d = FMT_S;
            7'b1100011:                                     fmt_d = FMT_B;
            7'b0110111, 7'b0010111:                         fmt_d = FMT_U;
            7'b1101111:                                     fmt_d = FMT_J;
            default:                                        fmt_d = FMT_ILL;
        endcase
    end

    always_comb begin
        imm_d = '0;
        case (fmt_d)
            FMT_I:   imm_d = {{20{sgn}}, inst[31:20]};
            FMT_S:   imm_d = {{20{sgn}}, inst[31:25], inst[11:7]};
            FMT_B:   imm_d = {{19{sgn}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm_d = {inst[31:12], 12'b0};
            FMT_J:   imm_d = {{11{sgn}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm_d = '0;
        endcase
    end

    // Writes to x0 are suppressed here so later stages never see a live x0 write.
    always_comb begin
        rd_we_d    = 1'b0;
        rs1_used_d = 1'b0;
        rs2_used_d = 1'b0;
        case (fmt_d)
            FMT_R: begin
                rd_we_d    = 1'b1;
                rs1_used_d = 1'b1;
                rs2_used_d = 1'b1;
            end
            FMT_I: begin
                rd_we_d    = 1'b1;
                rs1_used_d = 1'b1;
            end
            FMT_S, FMT_B: begin
                rs1_used_d = 1'b1;
                rs2_used_d = 1'b1;
            end
            FMT_U, FMT_J: rd_we_d = 1'b1;
            default: ;
        endcase
        if (inst[11:7] == 5'd0) rd_we_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_valid <= 1'b0;
            opcode    <= '0;
            rd        <= '0;
            funct3    <= '0;
            rs1       <= '0;
            rs2       <= '0;
            funct7    <= '0;
            imm       <= '0;
            fmt       <= '0;
            rd_we     <= 1'b0;
            rs1_used  <= 1'b0;
            rs2_used  <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            dec_valid <= inst_valid;
            opcode    <= inst[6:0];
            rd        <= inst[11:7];
            funct3    <= inst[14:12];
            rs1       <= inst[19:15];
            rs2       <= inst[24:20];
            funct7    <= inst[31:25];
            imm       <= imm_d;
            fmt       <= fmt_d;
            rd_we     <= rd_we_d;
            rs1_used  <= rs1_used_d;
            rs2_used  <= rs2_used_d;
            illegal   <= (fmt_d == FMT_ILL);
        end
    end

endmodule

// File: tb/tb_decode_unit.sv
// Directed and randomized checks of decode_unit against an arithmetic reference model.
module tb_decode_unit;

    typedef struct packed {
        logic        dv;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        we;
        logic        u1;
        logic        u2;
        logic        ill;
    } dec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic [31:0] inst;
    logic        dec_valid;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        rd_we;
    logic        rs1_used;
    logic        rs2_used;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;
    dec_t exp_prev;
    logic primed = 1'b0;

    decode_unit dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst),
        .dec_valid(dec_valid), .opcode(opcode), .rd(rd), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .funct7(funct7), .imm(imm), .fmt(fmt),
        .rd_we(rd_we), .rs1_used(rs1_used), .rs2_used(rs2_used), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic dec_t model(input logic v, input logic [31:0] i);
        dec_t d;
        int   x;
        int   k;
        d     = '0;
        d.dv  = v;
        d.op  = i[6:0];
        d.rd  = i[11:7];
        d.f3  = i[14:12];
        d.rs1 = i[19:15];
        d.rs2 = i[24:20];
        d.f7  = i[31:25];
        k     = int'(i[6:0]);
        if (k == 'h33) k = 0;
        else if (k == 'h13 || k == 'h03 || k == 'h67 || k == 'h73 || k == 'h0F) k = 1;
        else if (k == 'h23) k = 2;
        else if (k == 'h63) k = 3;
        else if (k == 'h37 || k == 'h17) k = 4;
        else if (k == 'h6F) k = 5;
        else k = 7;
        d.fmt = 3'(k);
        d.ill = (k == 7);
        x = 0;
        case (k)
            1: x = int'(i[31:20]) - (i[31] ? 4096 : 0);
            2: x = int'(i[31:25]) * 32 + int'(i[11:7]) - (i[31] ? 4096 : 0);
            3: x = int'(i[11:8]) * 2 + int'(i[30:25]) * 32 + int'(i[7]) * 2048 - (i[31] ? 4096 : 0);
            4: x = int'(i[31:12]) * 4096;
            5: x = int'(i[30:21]) * 2 + int'(i[20]) * 2048 + int'(i[19:12]) * 4096
                   - (i[31] ? 1048576 : 0);
            default: x = 0;
        endcase
        d.imm = x;
        d.we  = (k == 0 || k == 1 || k == 4 || k == 5) && (i[11:7] != 0);
        d.u1  = (k <= 3);
        d.u2  = (k == 0 || k == 2 || k == 3);
        return d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag, input dec_t e);
        chk({tag, ".dec_valid"}, 32'(dec_valid), 32'(e.dv));
        chk({tag, ".opcode"},    32'(opcode),    32'(e.op));
        chk({tag, ".rd"},        32'(rd),        32'(e.rd));
        chk({tag, ".funct3"},    32'(funct3),    32'(e.f3));
        chk({tag, ".rs1"},       32'(rs1),       32'(e.rs1));
        chk({tag, ".rs2"},       32'(rs2),       32'(e.rs2));
        chk({tag, ".funct7"},    32'(funct7),    32'(e.f7));
        chk({tag, ".imm"},       imm,            e.imm);
        chk({tag, ".fmt"},       32'(fmt),       32'(e.fmt));
        chk({tag, ".rd_we"},     32'(rd_we),     32'(e.we));
        chk({tag, ".rs1_used"},  32'(rs1_used),  32'(e.u1));
        chk({tag, ".rs2_used"},  32'(rs2_used),  32'(e.u2));
        chk({tag, ".illegal"},   32'(illegal),   32'(e.ill));
    endtask

    // Drive one cycle: outputs must hold the previous result until the edge, then show this one.
    task automatic step(input string tag, input logic r, input logic v, input logic [31:0] i);
        dec_t e;
        rst        = r;
        inst_valid = v;
        inst       = i;
        #2;
        if (primed) begin
            chk({tag, ".hold_imm"}, imm, exp_prev.imm);
            chk({tag, ".hold_fmt"}, 32'(fmt), 32'(exp_prev.fmt));
            chk({tag, ".hold_dv"},  32'(dec_valid), 32'(exp_prev.dv));
        end
        @(posedge clk);
        #1;
        e = r ? dec_t'('0) : model(v, i);
        check_all(tag, e);
        exp_prev = e;
        primed   = 1'b1;
    endtask

    task automatic chk_const(input string tag, input logic [31:0] imm_e, input logic [2:0] fmt_e);
        chk({tag, ".imm_const"}, imm, imm_e);
        chk({tag, ".fmt_const"}, 32'(fmt), 32'(fmt_e));
    endtask

    logic [6:0]  ops [11];
    logic [31:0] ri;
    logic        rr;

    initial begin
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        rst = 1'b1;
        inst_valid = 1'b1;
        inst = '1;
        @(negedge clk);

        step("rst0", 1'b1, 1'b1, 32'hFFFF_FFFF);
        step("rst1", 1'b1, 1'b1, 32'hFFFF_FFFF);

        step("add",    1'b0, 1'b1, 32'h0020_81B3); chk_const("add",    32'h0000_0000, 3'd0);
        step("addi",   1'b0, 1'b1, 32'h0540_8113); chk_const("addi",   32'h0000_0054, 3'd1);
        step("lui",    1'b0, 1'b1, 32'h0002_30B7); chk_const("lui",    32'h0002_3000, 3'd4);
        step("bne",    1'b0, 1'b1, 32'hFE11_1CE3); chk_const("bne",    32'hFFFF_FFF8, 3'd3);
        step("ill",    1'b0, 1'b1, 32'h0000_007F); chk_const("ill",    32'h0000_0000, 3'd7);
        chk("ill.illegal_const", 32'(illegal), 32'd1);
        step("addineg", 1'b0, 1'b1, 32'hFFF0_8113); chk_const("addineg", 32'hFFFF_FFFF, 3'd1);
        step("sw",     1'b0, 1'b1, 32'h0020_A223); chk_const("sw",     32'h0000_0004, 3'd2);
        step("jal",    1'b0, 1'b0, 32'h0080_006F); chk_const("jal",    32'h0000_0008, 3'd5);
        step("rstmid", 1'b1, 1'b1, 32'h0020_81B3);
        step("addx0",  1'b0, 1'b1, 32'h0020_8033);

        for (int n = 0; n < 400; n++) begin
            ri = $urandom;
            if ($urandom_range(0, 9) < 8) ri[6:0] = ops[$urandom_range(0, 10)];
            rr = ($urandom_range(0, 24) == 0);
            step("rand", rr, 1'($urandom_range(0, 1)), ri);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
